// File: rtl/csr_pins_in.sv
// csr_pins_in
//   CSR responder for COUNT external input pins (slide switches / keys). Each pin
//   passes through a 2-FF synchroniser, optional inversion, and a tick-based
//   debouncer. Rising edges of the debounced state are captured in sticky bits.
//   A maskable, registered level interrupt is raised while any enabled edge bit
//   is pending.
//
//   CSR map, relative to BASE_ADDR:
//     +0  STATE  debounced pin state, read-only (modify ops are accepted but ignored)
//     +1  EDGE   sticky rising edges; write and clear ops both clear where wdata=1
//     +2  IEN    interrupt enable; write / set / clear ops
//
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   read           CSR read strobe
//   modify         CSR modify op: 001 write, 010 set, 011 clear, others no-op
//   wdata          CSR write operand
//   addr           CSR address
//   rdata          read data, zero when this block is not addressed (OR-combined bus)
//   valid          one of the three CSRs is addressed with read or a non-zero modify
//   pins           raw asynchronous pin inputs
//   irq            |(edge & ien), registered
//   AVOID_WARNING  constant 0, also absorbs the otherwise unused operand bits
module csr_pins_in #(
   parameter logic [11:0]      BASE_ADDR    = 12'hBC3,
   parameter int               COUNT        = 18,
   parameter logic [COUNT-1:0] INVERT       = '0,
   parameter int               TICK_CYCLES  = 50_000,
   parameter int               STABLE_TICKS = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             read,
   input  logic [2:0]       modify,
   input  logic [31:0]      wdata,
   input  logic [11:0]      addr,
   output logic [31:0]      rdata,
   output logic             valid,
   input  logic [COUNT-1:0] pins,
   output logic             irq,
   output logic             AVOID_WARNING
);

   localparam int              TW          = $clog2(TICK_CYCLES);
   localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_CYCLES - 1);
   localparam logic [TW-1:0]   TICK_ONE    = TW'(1);
   localparam logic [3:0]      STABLE_LAST = 4'(STABLE_TICKS - 1);
   localparam logic [11:0]     ADDR_STATE  = BASE_ADDR;
   localparam logic [11:0]     ADDR_EDGE   = BASE_ADDR + 12'd1;
   localparam logic [11:0]     ADDR_IEN    = BASE_ADDR + 12'd2;
   localparam logic [2:0]      OP_WRITE    = 3'b001;
   localparam logic [2:0]      OP_SET      = 3'b010;
   localparam logic [2:0]      OP_CLEAR    = 3'b011;

   logic [COUNT-1:0]       sync1_r, sync2_r, state_r, edge_r, ien_r;
   logic [COUNT-1:0][3:0]  cnt_r;
   logic [TW-1:0]          tick_cnt_r;
   logic                   irq_r;

   logic                   tick_s;
   logic [COUNT-1:0]       state_next_s, edge_next_s, ien_next_s, edge_clr_s, wmask_s;
   logic [COUNT-1:0][3:0]  cnt_next_s;
   logic                   hit_state_s, hit_edge_s, hit_ien_s, valid_s;
   logic [31:0]            rdata_s;

   // Debounce sample strobe, one cycle per tick period.
   assign tick_s = (tick_cnt_r == TICK_LAST);

   // Per-bit debouncer: a bit flips only after STABLE_TICKS consecutive disagreeing ticks.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      for (int i = 0; i < COUNT; i++) begin
         if (!tick_s) begin
            cnt_next_s[i] = cnt_r[i];
         end else if (sync2_r[i] == state_r[i]) begin
            cnt_next_s[i] = 4'd0;                 // any agreeing tick restarts the count
         end else if (cnt_r[i] == STABLE_LAST) begin
            state_next_s[i] = sync2_r[i];
            cnt_next_s[i]   = 4'd0;
         end else begin
            cnt_next_s[i] = cnt_r[i] + 4'd1;
         end
      end
   end

   // CSR decode, read mux and next-state for the writable registers.
   always_comb begin
      hit_state_s = (addr == ADDR_STATE);
      hit_edge_s  = (addr == ADDR_EDGE);
      hit_ien_s   = (addr == ADDR_IEN);
      valid_s     = rstn & (read | (modify != 3'b000)) & (hit_state_s | hit_edge_s | hit_ien_s);
      wmask_s     = wdata[COUNT-1:0];

      // Write and clear both behave as W1C on EDGE; set is ignored.
      if (hit_edge_s && ((modify == OP_WRITE) || (modify == OP_CLEAR))) begin
         edge_clr_s = wmask_s;
      end else begin
         edge_clr_s = '0;
      end
      // A rising edge in the same cycle as its clear wins.
      edge_next_s = (edge_r & ~edge_clr_s) | (state_next_s & ~state_r);

      ien_next_s = ien_r;
      if (hit_ien_s) begin
         case (modify)
            OP_WRITE: ien_next_s = wmask_s;
            OP_SET:   ien_next_s = ien_r | wmask_s;
            OP_CLEAR: ien_next_s = ien_r & ~wmask_s;
            default:  ien_next_s = ien_r;
         endcase
      end else begin
         ien_next_s = ien_r;
      end

      rdata_s = 32'd0;
      if (!valid_s) begin
         rdata_s = 32'd0;
      end else if (hit_state_s) begin
         rdata_s[COUNT-1:0] = state_r;
      end else if (hit_edge_s) begin
         rdata_s[COUNT-1:0] = edge_r;
      end else begin
         rdata_s[COUNT-1:0] = ien_r;
      end
   end

   // Synchroniser, tick counter, debouncer, edge/ien registers and irq.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_r    <= '0;
         sync2_r    <= '0;
         state_r    <= '0;
         cnt_r      <= '0;
         tick_cnt_r <= '0;
         edge_r     <= '0;
         ien_r      <= '0;
         irq_r      <= 1'b0;
      end else begin
         sync1_r    <= pins ^ INVERT;
         sync2_r    <= sync1_r;
         state_r    <= state_next_s;
         cnt_r      <= cnt_next_s;
         tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TICK_ONE;
         edge_r     <= edge_next_s;
         ien_r      <= ien_next_s;
         irq_r      <= |(edge_next_s & ien_next_s);
      end
   end

   assign rdata         = rdata_s;
   assign valid         = valid_s;
   assign irq           = irq_r;
   assign AVOID_WARNING = &{1'b0, wdata};

endmodule

// File: tb/tb_csr_pins_in.sv
module tb_csr_pins_in;

   localparam int          TICK    = 4;
   localparam int          STABLE  = 3;
   localparam logic [11:0] A_STATE = 12'hBC3;
   localparam logic [11:0] A_EDGE  = 12'hBC4;
   localparam logic [11:0] A_IEN   = 12'hBC5;

   logic        clk, rstn, read, irq, avoid_warning, valid;
   logic [2:0]  modify;
   logic [31:0] wdata, rdata;
   logic [11:0] addr;
   logic [17:0] pins;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [17:0] m_s1, m_s2, m_st, m_edge, m_ien;
   int          m_run [18];
   int          m_edges;
   logic        m_irq;

   csr_pins_in #(
      .BASE_ADDR(12'hBC3), .COUNT(18), .INVERT(18'd0),
      .TICK_CYCLES(TICK), .STABLE_TICKS(STABLE)
   ) dut (
      .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
      .addr(addr), .rdata(rdata), .valid(valid), .pins(pins), .irq(irq),
      .AVOID_WARNING(avoid_warning)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_st = '0; m_edge = '0; m_ien = '0;
      m_irq = 1'b0; m_edges = 0;
      for (int i = 0; i < 18; i++) m_run[i] = 0;
   endtask

   function automatic logic exp_valid();
      return rstn && (read || modify != 3'd0) &&
             (addr == A_STATE || addr == A_EDGE || addr == A_IEN);
   endfunction

   function automatic logic [31:0] exp_rdata();
      logic [31:0] r;
      r = 32'd0;
      if (exp_valid()) begin
         if (addr == A_STATE)     r[17:0] = m_st;
         else if (addr == A_EDGE) r[17:0] = m_edge;
         else                     r[17:0] = m_ien;
      end
      return r;
   endfunction

   // Model of one rising clock edge using the inputs held across it.
   task automatic model_step();
      logic [17:0] old_s2, new_st, clr;
      bit          tick;
      if (!rstn) begin
         model_reset();
         return;
      end
      old_s2 = m_s2;
      tick   = ((m_edges % TICK) == TICK - 1);
      m_edges++;
      new_st = m_st;
      if (tick) begin
         for (int i = 0; i < 18; i++) begin
            if (old_s2[i] != m_st[i]) begin
               m_run[i]++;
               if (m_run[i] == STABLE) begin
                  new_st[i] = old_s2[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      clr = '0;
      if (addr == A_EDGE && (modify == 3'd1 || modify == 3'd3)) clr = wdata[17:0];
      m_edge = (m_edge & ~clr) | (new_st & ~m_st);
      if (addr == A_IEN) begin
         if (modify == 3'd1)      m_ien = wdata[17:0];
         else if (modify == 3'd2) m_ien = m_ien | wdata[17:0];
         else if (modify == 3'd3) m_ien = m_ien & ~wdata[17:0];
      end
      m_st  = new_st;
      m_s2  = m_s1;
      m_s1  = pins;
      m_irq = |(m_edge & m_ien);
   endtask

   function automatic bit will_rise5();
      return ((m_edges % TICK) == TICK - 1) && m_s2[5] && !m_st[5] && (m_run[5] == STABLE - 1);
   endfunction

   // Called with clk low: check bus outputs, clock once, check irq.
   task automatic step();
      #1;
      check_val("valid", {31'd0, valid}, {31'd0, exp_valid()});
      check_val("rdata", rdata, exp_rdata());
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_val("irq", {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic set_bus(input logic [11:0] a, input logic r, input logic [2:0] m, input logic [31:0] d);
      addr = a; read = r; modify = m; wdata = d;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      bit fired;
      rstn = 1'b0; pins = 18'd0;
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0);
      model_reset();
      steps(3);
      rstn = 1'b1;

      // reset in the middle of a debounce
      pins = 18'h3FFFF;
      steps(6);
      rstn = 1'b0;
      model_reset();
      #1;
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0); #1;
      check_val("rst_state", rdata, 32'd0);
      check_val("rst_valid", {31'd0, valid}, 32'd0);
      set_bus(A_EDGE, 1'b1, 3'd0, 32'd0); #1;
      check_val("rst_edge", rdata, 32'd0);
      set_bus(A_IEN, 1'b1, 3'd0, 32'd0); #1;
      check_val("rst_ien", rdata, 32'd0);
      check_val("rst_irq", {31'd0, irq}, 32'd0);
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0);
      steps(2);
      rstn = 1'b1;
      steps(2 + 3 * 4 + 4);
      check_val("rst_recover", rdata, 32'h0003_FFFF);

      // debounce: settle low, then a held rise on pin 0
      pins = 18'd0;
      steps(20);
      set_bus(A_EDGE, 1'b0, 3'd1, 32'hFFFF_FFFF); step();
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0);
      pins[0] = 1'b1;
      steps(20);
      check_val("deb_rise", {31'd0, rdata[0]}, 32'd1);
      pins[0] = 1'b0;
      steps(20);
      set_bus(A_EDGE, 1'b0, 3'd1, 32'h1); step();
      // two-tick pulse must be rejected
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0);
      pins[0] = 1'b1;
      steps(8);
      pins[0] = 1'b0;
      steps(20);
      check_val("glitch_state", {31'd0, rdata[0]}, 32'd0);
      set_bus(A_EDGE, 1'b1, 3'd0, 32'd0); #1;
      check_val("glitch_edge", {31'd0, rdata[0]}, 32'd0);

      // edge capture and irq
      set_bus(A_IEN, 1'b0, 3'd2, 32'h8); step();
      set_bus(A_EDGE, 1'b1, 3'd0, 32'd0);
      pins[3] = 1'b1;
      steps(20);
      check_val("edge3", rdata, 32'h8);
      check_val("irq_on", {31'd0, irq}, 32'd1);
      set_bus(A_EDGE, 1'b0, 3'd1, 32'h8); step();
      set_bus(A_EDGE, 1'b1, 3'd0, 32'd0); #1;
      check_val("edge_w1c", rdata, 32'd0);
      check_val("irq_off", {31'd0, irq}, 32'd0);
      pins[3] = 1'b0;
      steps(20);
      check_val("edge_fall", rdata, 32'd0);

      // W1C in the same cycle as the rise of bit 5
      fired = 1'b0;
      pins[5] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (!fired && will_rise5()) begin
            set_bus(A_EDGE, 1'b0, 3'd1, 32'h20);
            fired = 1'b1;
         end else begin
            set_bus(A_STATE, 1'b1, 3'd0, 32'd0);
         end
         step();
      end
      set_bus(A_EDGE, 1'b1, 3'd0, 32'd0); #1;
      check_val("collision", {31'd0, rdata[5]}, 32'd1);

      // IEN operations
      set_bus(A_IEN, 1'b0, 3'd1, 32'hFFFF_FFFF); step();
      set_bus(A_IEN, 1'b1, 3'd0, 32'd0); #1;
      check_val("ien_write", rdata, 32'h0003_FFFF);
      set_bus(A_IEN, 1'b0, 3'd3, 32'h1); step();
      set_bus(A_IEN, 1'b1, 3'd0, 32'd0); #1;
      check_val("ien_clear", rdata, 32'h0003_FFFE);
      set_bus(A_STATE, 1'b0, 3'd1, 32'd0); #1;
      check_val("state_wr_valid", {31'd0, valid}, 32'd1);
      step();
      set_bus(A_STATE, 1'b1, 3'd0, 32'd0); step();

      // decode boundaries
      set_bus(12'hBC2, 1'b1, 3'd0, 32'd0); #1;
      check_val("dec_bc2_valid", {31'd0, valid}, 32'd0);
      check_val("dec_bc2_rdata", rdata, 32'd0);
      set_bus(12'hBC6, 1'b1, 3'd0, 32'd0); #1;
      check_val("dec_bc6_valid", {31'd0, valid}, 32'd0);
      check_val("dec_bc6_rdata", rdata, 32'd0);
      set_bus(A_STATE, 1'b0, 3'd0, 32'd0); #1;
      check_val("dec_idle_valid", {31'd0, valid}, 32'd0);
      step();

      // randomized traffic against the model
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 11) == 0) pins = pins ^ (18'd1 << $urandom_range(0, 17));
         set_bus(12'hBC2 + 12'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0, $urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
